// File: rtl/cache_memory.sv
// Tag/valid/dirty/data storage and lookup for an N-way set-associative write-back cache.
// Defining CACHE_PERF_CNT_EN adds hit_count/miss_count access counters.
module cache_memory #(
    parameter int WORD_SIZE       = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int NUM_BLOCKS      = 64,
    parameter int NUM_WAYS        = 4,
    localparam int BLOCK_SIZE     = WORDS_PER_BLOCK * WORD_SIZE,
    localparam int NUM_SETS       = NUM_BLOCKS / NUM_WAYS,
    localparam int INDEX_WIDTH    = $clog2(NUM_SETS),
    localparam int OFFSET_WIDTH   = $clog2(WORDS_PER_BLOCK),
    localparam int TAG_WIDTH      = 32 - INDEX_WIDTH - OFFSET_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [TAG_WIDTH-1:0]    tag,
    input  logic [INDEX_WIDTH-1:0]  index,
    input  logic [OFFSET_WIDTH-1:0] blk_offset,
    input  logic                    req_type,
    input  logic                    read_en_cache,
    input  logic                    write_en_cache,
    input  logic                    read_en_mem,
    input  logic                    write_en_mem,
    input  logic [BLOCK_SIZE-1:0]   data_in_mem,
    input  logic [WORD_SIZE-1:0]    data_in,
    output logic [BLOCK_SIZE-1:0]   dirty_block_out,
    output logic                    hit,
    output logic [WORD_SIZE-1:0]    data_out,
    output logic                    dirty_bit
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
`endif
);

    localparam int ENTRY_W = BLOCK_SIZE + TAG_WIDTH + 2;
    localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    // Entry layout: {block, tag, dirty, valid}
    logic [ENTRY_W-1:0] cache [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]   rr_ptr [NUM_SETS];

    logic [WAY_W-1:0]      hit_way;
    logic [WAY_W-1:0]      victim;
    logic [ENTRY_W-1:0]    victim_entry;
    logic [BLOCK_SIZE-1:0] hit_block;
    logic [BLOCK_SIZE-1:0] wr_block;
    logic [BLOCK_SIZE-1:0] refill_block;
    logic [WORD_SIZE-1:0]  read_word;

    // Descending scans so the lowest-numbered qualifying way wins
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        victim  = rr_ptr[index];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (cache[index][w][0] &&
                cache[index][w][TAG_WIDTH+1:2] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!cache[index][w][0]) begin
                victim = WAY_W'(w);
            end
        end
    end

    always_comb begin
        victim_entry    = cache[index][victim];
        dirty_block_out = victim_entry[ENTRY_W-1 -: BLOCK_SIZE];
        dirty_bit       = victim_entry[1] & victim_entry[0];
        hit_block       = cache[index][hit_way][ENTRY_W-1 -: BLOCK_SIZE];
        read_word       = hit_block[blk_offset*WORD_SIZE +: WORD_SIZE];
        wr_block        = hit_block;
        wr_block[blk_offset*WORD_SIZE +: WORD_SIZE] = data_in;
        refill_block    = data_in_mem;
        if (req_type) begin
            refill_block[blk_offset*WORD_SIZE +: WORD_SIZE] = data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    cache[s][w][1:0] <= 2'b00;
                end
                rr_ptr[s] <= '0;
            end
            data_out <= '0;
        end else begin
            if (read_en_cache && hit) begin
                data_out <= read_word;
            end
            // Refill owns the set this cycle; cache writes and write-back wait
            if (read_en_mem) begin
                cache[index][victim] <= {refill_block, tag, req_type, 1'b1};
                rr_ptr[index] <= (rr_ptr[index] == WAY_W'(NUM_WAYS - 1)) ?
                                 '0 : rr_ptr[index] + 1'b1;
            end else begin
                if (write_en_mem) begin
                    cache[index][victim][1] <= 1'b0;
                end
                if (write_en_cache && hit) begin
                    cache[index][hit_way] <= {wr_block, tag, 1'b1, 1'b1};
                end
            end
        end
    end

`ifdef CACHE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (read_en_cache || write_en_cache) begin
            if (hit) begin
                hit_count <= hit_count + 32'd1;
            end else begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_memory.sv
// Randomized bench for cache_memory against a per-line behavioural model.
module tb_cache_memory;

    localparam int TW = 26;
    localparam int IW = 4;
    localparam int OW = 2;
    localparam int BS = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [TW-1:0] tag;
    logic [IW-1:0] index;
    logic [OW-1:0] blk_offset;
    logic          req_type, read_en_cache, write_en_cache;
    logic          read_en_mem, write_en_mem;
    logic [BS-1:0] data_in_mem;
    logic [31:0]   data_in;
    logic [BS-1:0] dirty_block_out;
    logic          hit;
    logic [31:0]   data_out;
    logic          dirty_bit;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0]   hit_count, miss_count;
`endif

    cache_memory dut (
        .clk(clk), .rst_n(rst_n), .tag(tag), .index(index),
        .blk_offset(blk_offset), .req_type(req_type),
        .read_en_cache(read_en_cache), .write_en_cache(write_en_cache),
        .read_en_mem(read_en_mem), .write_en_mem(write_en_mem),
        .data_in_mem(data_in_mem), .data_in(data_in),
        .dirty_block_out(dirty_block_out), .hit(hit),
        .data_out(data_out), .dirty_bit(dirty_bit)
`ifdef CACHE_PERF_CNT_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: one record per line, words kept individually
    logic          mval   [16][4];
    logic          mdirty [16][4];
    logic [TW-1:0] mtag   [16][4];
    logic [31:0]   mword  [16][4][4];
    int            mrr    [16];
    logic [31:0]   mdout;
    logic [31:0]   mhc, mmc;

    task automatic check(input string name, input logic [BS-1:0] got,
                         input logic [BS-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int m_hit_way(input int s, input logic [TW-1:0] t);
        for (int w = 0; w < 4; w++)
            if (mval[s][w] && mtag[s][w] == t) return w;
        return -1;
    endfunction

    function automatic int m_victim(input int s);
        for (int w = 0; w < 4; w++)
            if (!mval[s][w]) return w;
        return mrr[s];
    endfunction

    function automatic logic [BS-1:0] m_block(input int s, input int w);
        logic [BS-1:0] b;
        for (int k = 0; k < 4; k++) b[k*32 +: 32] = mword[s][w][k];
        return b;
    endfunction

    task automatic m_reset();
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 4; w++) begin
                mval[s][w]   = 1'b0;
                mdirty[s][w] = 1'b0;
            end
            mrr[s] = 0;
        end
        mdout = '0;
        mhc   = '0;
        mmc   = '0;
    endtask

    task automatic preload(input int s, input int w, input logic [TW-1:0] t,
                           input logic [BS-1:0] b, input logic d);
        dut.cache[s][w] <= {b, t, d, 1'b1};
        mval[s][w]   = 1'b1;
        mdirty[s][w] = d;
        mtag[s][w]   = t;
        for (int k = 0; k < 4; k++) mword[s][w][k] = b[k*32 +: 32];
    endtask

    task automatic step(input int s, input logic [TW-1:0] t, input int off,
                        input logic rt, input logic rc, input logic wc,
                        input logic rm, input logic wm,
                        input logic [BS-1:0] dm, input logic [31:0] din);
        int h, v;
        @(negedge clk);
        index = IW'(s); tag = t; blk_offset = OW'(off); req_type = rt;
        read_en_cache = rc; write_en_cache = wc;
        read_en_mem = rm; write_en_mem = wm;
        data_in_mem = dm; data_in = din;
        #1;
        h = m_hit_way(s, t);
        v = m_victim(s);
        check("hit", BS'(hit), BS'(h >= 0));
        check("dirty_bit", BS'(dirty_bit), BS'(mval[s][v] && mdirty[s][v]));
        if (mval[s][v]) check("dirty_block_out", dirty_block_out, m_block(s, v));
        @(posedge clk);
        if (rc && h >= 0) mdout = mword[s][h][off];
        if (rc || wc) begin
            if (h >= 0) mhc++;
            else mmc++;
        end
        if (rm) begin
            mval[s][v]   = 1'b1;
            mdirty[s][v] = rt;
            mtag[s][v]   = t;
            for (int k = 0; k < 4; k++) mword[s][v][k] = dm[k*32 +: 32];
            if (rt) mword[s][v][off] = din;
            mrr[s] = (mrr[s] + 1) % 4;
        end else begin
            if (wm) mdirty[s][v] = 1'b0;
            if (wc && h >= 0) begin
                mword[s][h][off] = din;
                mdirty[s][h]     = 1'b1;
            end
        end
        #1;
        check("data_out", BS'(data_out), BS'(mdout));
`ifdef CACHE_PERF_CNT_EN
        check("hit_count", BS'(hit_count), BS'(mhc));
        check("miss_count", BS'(miss_count), BS'(mmc));
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        read_en_cache  = 1'($urandom);
        write_en_cache = 1'($urandom);
        read_en_mem    = 1'($urandom);
        write_en_mem   = 1'($urandom);
        rst_n = 1'b0;
        m_reset();
        #1;
        check("rst_data_out", BS'(data_out), BS'(0));
        check("rst_dirty_bit", BS'(dirty_bit), BS'(0));
        check("rst_hit", BS'(hit), BS'(0));
        @(posedge clk);
        #1;
        check("rst_hold_data_out", BS'(data_out), BS'(0));
        @(negedge clk);
        rst_n = 1'b1;
        read_en_cache = 0; write_en_cache = 0;
        read_en_mem = 0; write_en_mem = 0;
    endtask

    logic [TW-1:0] pool [6];
    logic [BS-1:0] rblk;

    initial begin
        rst_n = 1'b0;
        tag = '0; index = '0; blk_offset = '0; req_type = 1'b0;
        read_en_cache = 0; write_en_cache = 0;
        read_en_mem = 0; write_en_mem = 0;
        data_in_mem = '0; data_in = '0;
        pool[0] = 26'h1ABCDE; pool[1] = 26'h2BCDEF; pool[2] = 26'h3CDEF0;
        pool[3] = 26'h4DEF01; pool[4] = 26'h0000123; pool[5] = 26'h0000777;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_data_out", BS'(data_out), BS'(0));
        check("reset_dirty_bit", BS'(dirty_bit), BS'(0));
        check("reset_rr_ptr", BS'(dut.rr_ptr[0]), BS'(0));
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        preload(0, 0, 26'h1ABCDE,
                128'hAAAABBBB_CCCC1111_DDDD2222_EEEE3333, 1'b0);
        preload(0, 1, 26'h2BCDEF, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        preload(0, 2, 26'h3CDEF0, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        preload(0, 3, 26'h4DEF01,
                128'h11112222_33334444_55556666_77778888, 1'b0);

        step(0, 26'h1ABCDE, 2, 0, 1, 0, 0, 0, '0, '0);
        step(0, 26'h1ABCDE, 2, 0, 1, 0, 0, 0, '0, '0);
        check("tp_read_way0", BS'(data_out), BS'(32'hCCCC1111));
        step(0, 26'h4DEF01, 0, 0, 1, 0, 0, 0, '0, '0);
        check("tp_read_way3", BS'(data_out), BS'(32'h77778888));
        step(0, 26'h3FFFFFF, 0, 0, 1, 0, 0, 0, '0, '0);
        check("tp_miss_hit", BS'(hit), BS'(0));
        check("tp_miss_hold", BS'(data_out), BS'(32'h77778888));
        check("tp_miss_dirty", BS'(dirty_bit), BS'(0));

        step(0, 26'h1ABCDE, 1, 1, 0, 1, 0, 0, '0, 32'h12345678);
        step(0, 26'h1ABCDE, 1, 0, 1, 0, 0, 0, '0, '0);
        check("tp_write_read", BS'(data_out), BS'(32'h12345678));
        check("tp_write_dirty", BS'(dut.cache[0][0][1]), BS'(1));

        step(5, 26'h0000123, 0, 0, 0, 0, 1, 0,
             128'h00000003_00000002_00000001_0000000A, '0);
        step(5, 26'h0000123, 0, 0, 1, 0, 0, 0, '0, '0);
        check("tp_refill_read", BS'(data_out), BS'(32'h0000000A));
        check("tp_refill_rr", BS'(dut.rr_ptr[5]), BS'(1));

        step(0, 26'h1ABCDE, 0, 0, 0, 0, 0, 0, '0, '0);
        check("tp_evict_dirty", BS'(dirty_bit), BS'(1));
        check("tp_evict_block", dirty_block_out,
              128'hAAAABBBB_CCCC1111_12345678_EEEE3333);
        step(0, 26'h1ABCDE, 0, 0, 0, 0, 0, 1, '0, '0);
        check("tp_wb_clear", BS'(dirty_bit), BS'(0));
        step(0, 26'h0000777, 0, 0, 0, 0, 1, 0,
             128'h44444444_33333333_22222222_11111111, '0);
        check("tp_evict_tag", BS'(dut.cache[0][0][27:2]), BS'(26'h0000777));
        step(0, 26'h0000777, 3, 0, 1, 0, 0, 0, '0, '0);
        check("tp_evict_read", BS'(data_out), BS'(32'h44444444));

        for (int i = 0; i < 600; i++) begin
            int s, op, off;
            logic [TW-1:0] t;
            logic [31:0] din;
            if (i % 200 == 150) do_reset();
            s    = $urandom_range(0, 3);
            t    = pool[$urandom_range(0, 5)];
            off  = $urandom_range(0, 3);
            op   = $urandom_range(0, 9);
            din  = $urandom;
            rblk = {$urandom, $urandom, $urandom, $urandom};
            case (op)
                0, 1, 2: step(s, t, off, 0, 1, 0, 0, 0, rblk, din);
                3, 4:    step(s, t, off, 1, 0, 1, 0, 0, rblk, din);
                5:       step(s, t, off, 1, 1, 1, 0, 0, rblk, din);
                6:       step(s, t, off, 1'($urandom), 1'($urandom),
                              1'($urandom), 1, 1'($urandom), rblk, din);
                7:       step(s, t, off, 0, 0, 0, 0, 1, rblk, din);
                8:       step(s, t, off, 1, 1'($urandom), 1, 0, 1, rblk, din);
                default: step(s, t, off, 0, 0, 0, 0, 0, rblk, din);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
